// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and default widths for the CPU codebase slice.
//   opcode_t       - 3-bit instruction opcodes (HLT..JMP)
//   fetch_state_t  - fetch stage FSM states
//   AWIDTH_DEF / DWIDTH_DEF / OPW_DEF - default address, word and opcode widths
package cpu_pkg;

  localparam int AWIDTH_DEF = 5;
  localparam int OPW_DEF    = 3;
  localparam int DWIDTH_DEF = OPW_DEF + AWIDTH_DEF;

  typedef enum logic [2:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter register.
//   clk, rst     - clock, synchronous active-high reset (count -> 0)
//   load         - load load_value (highest priority)
//   load_value   - jump target
//   inc          - increment request
//   inc_enable   - gates inc; an increment happens only when both are high
//   count        - current value, wraps modulo 2^AWIDTH
module pc_counter #(
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [AWIDTH-1:0] load_value,
  input  logic              inc,
  input  logic              inc_enable,
  output logic [AWIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && inc_enable) begin
      count <= count + AWIDTH'(1);  // natural wrap at 2^AWIDTH
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of the CPU control unit.
//   clk, rst            - clock, synchronous active-high reset
//   mem_req/mem_addr    - read request and address to program memory
//   mem_rdata/mem_ack   - read data, valid in the cycle mem_ack=1
//   ir_valid/ir_opcode/ir_operand/ir_ready
//                       - valid/ready instruction register toward control
//   pc_load/pc_load_addr, skip
//                       - jump and skip requests, sampled only on accept
//   resume              - leave HALT and fetch from the current pc
//   halt                - fetch stopped on HLT
//   pc                  - current program counter
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int OPW    = OPW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              ir_valid,
  output logic [OPW-1:0]    ir_opcode,
  output logic [AWIDTH-1:0] ir_operand,
  input  logic              ir_ready,
  input  logic              pc_load,
  input  logic [AWIDTH-1:0] pc_load_addr,
  input  logic              skip,
  input  logic              resume,
  output logic              halt,
  output logic [AWIDTH-1:0] pc
);

  fetch_state_t state;

  logic accept;
  logic is_hlt;
  logic fetch_done;
  logic jump;
  logic skip_taken;

  // ir_valid is only ever set in HOLD, so this is the HOLD-state accept.
  assign accept     = ir_valid && ir_ready;
  assign is_hlt     = (ir_opcode == OPW'(HLT));
  assign fetch_done = (state == WAIT) && mem_ack;
  // Jump beats skip; neither applies when the accepted word is HLT.
  assign jump       = accept && !is_hlt && pc_load;
  assign skip_taken = accept && !is_hlt && !pc_load && skip;

  pc_counter #(
    .AWIDTH(AWIDTH)
  ) u_pc_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (jump),
    .load_value(pc_load_addr),
    .inc       (fetch_done || skip_taken),
    .inc_enable(state != HALT),
    .count     (pc)
  );

  always_ff @(posedge clk) begin
    // NOTE: reset is checked first so it also wins over an ack in the same
    // cycle; a read completing during reset is dropped.
    if (rst) begin
      state      <= FETCH;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      ir_valid   <= 1'b0;
      ir_opcode  <= '0;
      ir_operand <= '0;
      halt       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          mem_req  <= 1'b1;
          mem_addr <= pc;
          state    <= WAIT;
        end
        WAIT: begin
          // Request and address stay put until the memory answers.
          if (mem_ack) begin
            ir_opcode  <= mem_rdata[DWIDTH-1 -: OPW];
            ir_operand <= mem_rdata[AWIDTH-1:0];
            mem_req    <= 1'b0;
            ir_valid   <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            ir_valid <= 1'b0;
            if (is_hlt) begin
              halt  <= 1'b1;
              state <= HALT;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: begin
          if (resume) begin
            halt  <= 1'b0;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
